// File: rtl/mem_inst_sequencer_if.sv
// Bus bundle between the instruction sequencer and its ROM, read, shift and wake peers.
interface mem_inst_sequencer_if #(
  parameter int INST_WIDTH = 56,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_LANES  = 16
);
  logic                   START;
  logic                   STOP;
  logic [ADDR_WIDTH-1:0]  ROM_ADDRESS;
  logic                   ROM_ENABLE;
  logic [INST_WIDTH-1:0]  ROM_DATA;
  logic [3:0]             RD_REQ;
  logic                   RD_READY;
  logic                   SHIFT_VALID;
  logic [3:0]             SHIFT_AMOUNT;
  logic [3*NUM_LANES-1:0] LANE_SEL;
  logic                   SHIFT_READY;
  logic                   WFI_ACTIVE;
  logic                   WAKE;
  logic                   ITER_DONE;
  logic [15:0]            LOOP_COUNT;
  logic                   BUSY;
  logic                   ILLEGAL;

  modport master (
    input  START, STOP, ROM_DATA, RD_READY, SHIFT_READY, WAKE,
    output ROM_ADDRESS, ROM_ENABLE, RD_REQ, SHIFT_VALID, SHIFT_AMOUNT, LANE_SEL,
           WFI_ACTIVE, ITER_DONE, LOOP_COUNT, BUSY, ILLEGAL
  );

  modport slave (
    output START, STOP, ROM_DATA, RD_READY, SHIFT_READY, WAKE,
    input  ROM_ADDRESS, ROM_ENABLE, RD_REQ, SHIFT_VALID, SHIFT_AMOUNT, LANE_SEL,
           WFI_ACTIVE, ITER_DONE, LOOP_COUNT, BUSY, ILLEGAL
  );
endinterface

// File: rtl/mem_inst_sequencer.sv
// Fetch/decode/execute sequencer for memory-interface micro-instructions held in a ROM.
module mem_inst_sequencer #(
  parameter int INST_WIDTH = 56,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_LANES  = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  mem_inst_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, READ, SHIFT, WFI, HALT
  } state_t;

  localparam logic [2:0] OP_READ  = 3'b000;
  localparam logic [2:0] OP_SHIFT = 3'b101;
  localparam logic [2:0] OP_WFI   = 3'b110;
  localparam logic [2:0] OP_LOOP  = 3'b111;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [3:0]             arg_q, arg_d;
  logic [3*NUM_LANES-1:0] lanes_q, lanes_d;
  logic [15:0]            loop_count_q, loop_count_d;
  logic                   iter_done_q, iter_done_d;
  logic                   illegal_q, illegal_d;
  logic                   stop_q, stop_d;

  logic                   rom_en;
  logic [3:0]             rd_req;
  logic                   shift_valid;
  logic [3:0]             shift_amount;
  logic [3*NUM_LANES-1:0] lane_sel;
  logic                   wfi_active;
  logic [2:0]             opcode;
  logic                   stop_pending;

  assign opcode       = bus.ROM_DATA[6:4];
  assign stop_pending = stop_q | bus.STOP;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      arg_q        <= '0;
      lanes_q      <= '0;
      loop_count_q <= '0;
      iter_done_q  <= 1'b0;
      illegal_q    <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      arg_q        <= arg_d;
      lanes_q      <= lanes_d;
      loop_count_q <= loop_count_d;
      iter_done_q  <= iter_done_d;
      illegal_q    <= illegal_d;
      stop_q       <= stop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    arg_d        = arg_q;
    lanes_d      = lanes_q;
    loop_count_d = loop_count_q;
    iter_done_d  = 1'b0;
    illegal_d    = illegal_q;
    stop_d       = stop_pending;
    rom_en       = 1'b0;
    rd_req       = '0;
    shift_valid  = 1'b0;
    shift_amount = '0;
    lane_sel     = '0;
    wfi_active   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        rom_en  = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        // Dispatch straight from ROM_DATA; only the operand fields are kept.
        arg_d   = bus.ROM_DATA[3:0];
        lanes_d = bus.ROM_DATA[8 +: 3*NUM_LANES];
        case (opcode)
          OP_READ: begin
            if (bus.ROM_DATA[3:0] == 4'd0) begin
              pc_d    = pc_q + 1'b1;
              state_d = FETCH;
            end else begin
              state_d = READ;
            end
          end
          OP_SHIFT: state_d = SHIFT;
          OP_WFI:   state_d = WFI;
          OP_LOOP: begin
            pc_d         = '0;
            iter_done_d  = 1'b1;
            loop_count_d = loop_count_q + 16'd1;
            if (stop_pending) begin
              stop_d  = 1'b0;
              state_d = HALT;
            end else begin
              state_d = FETCH;
            end
          end
          default: begin
            illegal_d = 1'b1;
            pc_d      = pc_q + 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      READ: begin
        rd_req = arg_q;
        if (bus.RD_READY) begin
          pc_d    = pc_q + 1'b1;
          state_d = FETCH;
        end
      end
      SHIFT: begin
        shift_valid  = 1'b1;
        shift_amount = arg_q;
        lane_sel     = lanes_q;
        if (bus.SHIFT_READY) begin
          pc_d    = pc_q + 1'b1;
          state_d = FETCH;
        end
      end
      WFI: begin
        wfi_active = 1'b1;
        if (bus.WAKE) begin
          pc_d    = pc_q + 1'b1;
          state_d = FETCH;
        end
      end
      HALT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ROM_ADDRESS  = pc_q;
  assign bus.ROM_ENABLE   = rom_en;
  assign bus.RD_REQ       = rd_req;
  assign bus.SHIFT_VALID  = shift_valid;
  assign bus.SHIFT_AMOUNT = shift_amount;
  assign bus.LANE_SEL     = lane_sel;
  assign bus.WFI_ACTIVE   = wfi_active;
  assign bus.ITER_DONE    = iter_done_q;
  assign bus.LOOP_COUNT   = loop_count_q;
  assign bus.BUSY         = (state_q != IDLE);
  assign bus.ILLEGAL      = illegal_q;
endmodule

// File: doc/mem_inst_sequencer.md
MEM_INST_SEQUENCER -- requirements
Module: mem_inst_sequencer

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 56, meaning the memory-interface instruction width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, meaning the instruction ROM address width.
REQ-003 SHALL have parameter NUM_LANES, default 16, meaning the number of shifter lanes, each with a 3-bit select field.
REQ-004 SHALL have port CLK, input, 1 bit, clock; all state changes on the rising edge.
REQ-005 SHALL have port RESET, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port START, input, 1 bit, begin execution from address 0 while idle.
REQ-007 SHALL have port STOP, input, 1 bit, sticky request to halt at the next loop instruction.
REQ-008 SHALL have port ROM_ADDRESS, output, ADDR_WIDTH bits, fetch address (PC).
REQ-009 SHALL have port ROM_ENABLE, output, 1 bit, fetch strobe.
REQ-010 SHALL have port ROM_DATA, input, INST_WIDTH bits, instruction registered by the ROM one cycle after ROM_ENABLE.
REQ-011 SHALL have port RD_REQ, output, 4 bits, per-bus read request mask.
REQ-012 SHALL have port RD_READY, input, 1 bit, read accepted.
REQ-013 SHALL have port SHIFT_VALID, output, 1 bit, shift command valid.
REQ-014 SHALL have port SHIFT_AMOUNT, output, 4 bits, shift distance.
REQ-015 SHALL have port LANE_SEL, output, 3*NUM_LANES bits, per-lane select; 0 means the lane is idle.
REQ-016 SHALL have port SHIFT_READY, input, 1 bit, shift accepted.
REQ-017 SHALL have port WFI_ACTIVE, output, 1 bit, waiting for WAKE.
REQ-018 SHALL have port WAKE, input, 1 bit, releases a wait-for-interrupt.
REQ-019 SHALL have port ITER_DONE, output, 1 bit, one-cycle pulse on each executed loop instruction.
REQ-020 SHALL have port LOOP_COUNT, output, 16 bits, count of executed loops (wraps).
REQ-021 SHALL have port BUSY, output, 1 bit, high in every state other than IDLE.
REQ-022 SHALL have port ILLEGAL, output, 1 bit, sticky flag set when an undefined opcode is decoded.

Function
REQ-023 SHALL decode the opcode from inst[6:4]: 000 read, 101 shift, 110 wfi, 111 loop; any other value is illegal.
REQ-024 SHALL use the states IDLE, FETCH, DECODE, READ, SHIFT, WFI and HALT.
REQ-025 IDLE: on START, SHALL clear PC to 0 and go to FETCH; START outside IDLE SHALL be ignored.
REQ-026 FETCH: SHALL assert ROM_ENABLE with ROM_ADDRESS=PC for exactly one cycle, then go to DECODE.
REQ-027 DECODE: SHALL capture ROM_DATA into the instruction register and dispatch on the opcode; ROM_ENABLE SHALL be low.
REQ-028 Read: SHALL drive RD_REQ=inst[3:0] in READ and hold it until RD_READY; RD_READY=1 SHALL complete READ and advance to FETCH in the same edge.
REQ-029 Read with inst[3:0]=0: SHALL issue no request and go directly to FETCH.
REQ-030 Shift: in SHIFT, SHALL drive SHIFT_VALID=1, SHIFT_AMOUNT=inst[3:0] and LANE_SEL=inst[8+3*NUM_LANES-1:8], held stable until SHIFT_READY.
REQ-031 WFI: WFI_ACTIVE SHALL be 1 in WFI; WAKE SHALL advance to FETCH; WAKE asserted outside WFI SHALL be ignored (not remembered).
REQ-032 Loop: SHALL set PC to 0, pulse ITER_DONE, and increment LOOP_COUNT modulo 2^16; if STOP is pending, SHALL go to HALT and clear the pending STOP, else go to FETCH.
REQ-033 HALT: SHALL return to IDLE on the next cycle.
REQ-034 Illegal opcode: SHALL set ILLEGAL and treat the instruction as a one-slot no-op.
REQ-035 PC SHALL increment by 1 on completion of each non-loop instruction and wrap from 2^ADDR_WIDTH-1 to 0.
REQ-036 RD_REQ, SHIFT_VALID, LANE_SEL and SHIFT_AMOUNT SHALL be zero outside their own states.
REQ-037 Minimum cost SHALL be 2 cycles per instruction: read/shift 3 cycles when ready is already high, loop 2 cycles.

Reset
REQ-038 RESET SHALL force IDLE, PC=0, LOOP_COUNT=0, ILLEGAL=0, clear a pending STOP, and drive all outputs to 0, taking priority over every other input, including mid-handshake.

Verification
REQ-039 Program {read 0001, loop}, START, RD_READY=1 -> RD_REQ=0001 for one cycle, ITER_DONE at the loop, LOOP_COUNT=1, then refetch of address 0.
REQ-040 Shift inst with amount 15, lanes 1-4 sel=1, SHIFT_READY low 5 cycles -> SHIFT_VALID/LANE_SEL stable for 6 cycles, PC +1 after acceptance.
REQ-041 WFI at address 46 with WAKE pulsed before entry and 3 cycles after entry -> the early pulse is ignored, exit follows the late pulse, and the next fetch is address 47.
REQ-042 STOP asserted mid-program -> execution continues to the loop, then HALT, then IDLE; BUSY=0; LOOP_COUNT increments once.
REQ-043 Opcode 3'b010 -> ILLEGAL=1, no RD/SHIFT activity, next fetch at PC+1.
REQ-044 RESET during READ with RD_READY=0 -> RD_REQ=0 next cycle, state IDLE, LOOP_COUNT=0.
